// File: rtl/contador_0_999.sv
`default_nettype none
// ============================================================================
// Module   : contador_0_999
// Purpose  : Button-controlled decimal counter for a three-digit display.
//            Counts 0..MAX_VALUE at TICK_HZ, up or down, with start/stop and
//            clear keys debounced on chip. Feeds the bin-to-7seg converter.
// Revision : 1.0  initial release
// ============================================================================
module contador_0_999 #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int MAX_VALUE       = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_stop_n,
    input  logic       key_clear_n,
    input  logic       sw_dir,
    output logic [9:0] number_out,
    output logic       running,
    output logic       wrap_pulse
);

    localparam int C_PRESC   = CLK_HZ / TICK_HZ;
    localparam int C_PRESC_W = (C_PRESC > 1) ? $clog2(C_PRESC) : 1;
    localparam int C_DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(C_PRESC - 1);
    localparam logic [C_DEB_W-1:0]   C_DEB_LAST   = C_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]           C_MAX        = 10'(MAX_VALUE);
    localparam int C_NKEYS   = 2;          // bit 0: start/stop, bit 1: clear
    localparam int C_DIR_BIT = 2;          // sync bit carrying sw_dir

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             sync1_q, sync2_q;
    logic [C_PRESC_W-1:0]   presc_q, presc_d;
    logic [9:0]             number_q, number_d;
    logic                   wrap_q, wrap_d;
    logic [C_NKEYS-1:0]     w_press;
    logic                   w_start;
    logic                   w_clear;
    logic                   w_tick;

    // Two-flop synchronizers for the raw asynchronous inputs; idle level is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {sw_dir, key_clear_n, key_start_stop_n};
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < C_NKEYS; k++) begin : g_debounce
        logic [C_DEB_W-1:0] cnt_q, cnt_d;
        logic               level_q, level_d;
        logic               press_q, press_d;

        // Accept a new level only after it has been stable for the full window.
        always_comb begin
            cnt_d   = '0;
            level_d = level_q;
            press_d = 1'b0;
            if (sync2_q[k] != level_q) begin
                if (cnt_q == C_DEB_LAST) begin
                    level_d = sync2_q[k];
                    press_d = ~sync2_q[k];
                end else begin
                    cnt_d = cnt_q + C_DEB_W'(1);
                end
            end
        end

        // Debounce state registers; keys reset to the released level.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end

        assign w_press[k] = press_q;
    end

    assign w_start = w_press[0];
    assign w_clear = w_press[1];
    assign w_tick  = (state_q == ST_RUN) && (presc_q == C_PRESC_LAST);

    // Next-state logic: clear overrides and discards a simultaneous start/stop.
    always_comb begin
        state_d = state_q;
        if (w_clear) begin
            state_d = ST_IDLE;
        end else if (w_start) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler and counter datapath; the count never leaves 0..MAX_VALUE.
    always_comb begin
        presc_d  = presc_q;
        number_d = number_q;
        wrap_d   = 1'b0;
        if (w_clear) begin
            presc_d  = '0;
            number_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = w_tick ? '0 : presc_q + C_PRESC_W'(1);
            if (w_tick) begin
                if (sync2_q[C_DIR_BIT]) begin
                    if (number_q >= C_MAX) begin
                        number_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        number_d = number_q + 10'd1;
                    end
                end else begin
                    if (number_q == '0) begin
                        number_d = C_MAX;
                        wrap_d   = 1'b1;
                    end else begin
                        number_d = number_q - 10'd1;
                    end
                end
            end
        end else if (state_q == ST_IDLE) begin
            presc_d = '0;
        end
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            number_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            number_q <= number_d;
            wrap_q   <= wrap_d;
        end
    end

    assign number_out = number_q;
    assign wrap_pulse = wrap_q;
    assign running    = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_contador_0_999.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_0_999
// Purpose  : Directed self-checking bench for contador_0_999 with small
//            timing parameters (PRESC=10, DEBOUNCE_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_contador_0_999;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_ss_n;
    logic       key_clr_n;
    logic       sw_dir;
    logic [9:0] number_out;
    logic       running;
    logic       wrap_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [9:0] num;
        logic       run;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    contador_0_999 #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (4),
        .MAX_VALUE       (999)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .key_start_stop_n (key_ss_n),
        .key_clear_n      (key_clr_n),
        .sw_dir           (sw_dir),
        .number_out       (number_out),
        .running          (running),
        .wrap_pulse       (wrap_pulse)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] num,
                              input logic run, input logic wrap);
        exp_t e;
        e.tag  = tag;
        e.num  = num;
        e.run  = run;
        e.wrap = wrap;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: got no queued entry, required one");
        end else begin
            e = sb.pop_front();
            assert (number_out === e.num && running === e.run && wrap_pulse === e.wrap)
            else begin
                failures++;
                $error("FAIL %s: got num=%0d run=%b wrap=%b, required num=%0d run=%b wrap=%b",
                       e.tag, number_out, running, wrap_pulse, e.num, e.run, e.wrap);
            end
        end
    endtask

    // Raw edge to state change is 2 sync + 4 debounce + 1 = 7 edges.
    task automatic start_press();
        key_ss_n = 1'b0;
        cyc(7);
        key_ss_n = 1'b1;
    endtask

    task automatic clear_press();
        key_clr_n = 1'b0;
        cyc(7);
        key_clr_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        key_ss_n  = 1'b0;
        key_clr_n = 1'b1;
        sw_dir    = 1'b1;

        // Reset held 3 cycles while a key is pressed
        expect_out("reset_state", 10'd0, 1'b0, 1'b0);
        cyc(3);
        check_out();
        rst      = 1'b0;
        key_ss_n = 1'b1;
        expect_out("no_press_after_reset", 10'd0, 1'b0, 1'b0);
        cyc(20);
        check_out();

        // Glitch shorter than the debounce window
        key_ss_n = 1'b0;
        expect_out("glitch_ignored", 10'd0, 1'b0, 1'b0);
        cyc(3);
        key_ss_n = 1'b1;
        cyc(10);
        check_out();

        // Held press: state changes exactly 7 edges after the raw edge
        key_ss_n = 1'b0;
        expect_out("latency_6_not_yet", 10'd0, 1'b0, 1'b0);
        cyc(6);
        check_out();
        expect_out("latency_7_running", 10'd0, 1'b1, 1'b0);
        cyc(1);
        check_out();
        cyc(13);
        key_ss_n = 1'b1;
        expect_out("single_press_held", 10'd2, 1'b1, 1'b0);
        cyc(10);
        check_out();

        expect_out("clear_to_idle", 10'd0, 1'b0, 1'b0);
        clear_press();
        check_out();
        cyc(10);

        // Count, pause, hold, resume the partial period
        sw_dir = 1'b1;
        expect_out("run_start", 10'd0, 1'b1, 1'b0);
        start_press();
        check_out();
        expect_out("count_50_cycles", 10'd5, 1'b1, 1'b0);
        cyc(50);
        check_out();
        cyc(1);
        expect_out("paused", 10'd5, 1'b0, 1'b0);
        start_press();
        check_out();
        expect_out("pause_holds", 10'd5, 1'b0, 1'b0);
        cyc(100);
        check_out();
        expect_out("resume", 10'd5, 1'b1, 1'b0);
        start_press();
        check_out();
        expect_out("resume_partial_1", 10'd5, 1'b1, 1'b0);
        cyc(1);
        check_out();
        expect_out("resume_partial_2", 10'd6, 1'b1, 1'b0);
        cyc(1);
        check_out();

        // Wrap up at 999, then wrap down at 0
        expect_out("reach_999", 10'd999, 1'b1, 1'b0);
        cyc(9930);
        check_out();
        expect_out("wrap_up", 10'd0, 1'b1, 1'b1);
        cyc(10);
        check_out();
        expect_out("wrap_up_pulse_end", 10'd0, 1'b1, 1'b0);
        cyc(1);
        check_out();
        sw_dir = 1'b0;
        expect_out("wrap_down", 10'd999, 1'b1, 1'b1);
        cyc(9);
        check_out();
        expect_out("wrap_down_pulse_end", 10'd999, 1'b1, 1'b0);
        cyc(1);
        check_out();

        // Direction changes mid-run at 10 and at 20
        expect_out("clear_before_dir", 10'd0, 1'b0, 1'b0);
        clear_press();
        check_out();
        cyc(10);
        sw_dir = 1'b1;
        cyc(3);
        start_press();
        for (int v = 1; v <= 10; v++) begin
            expect_out("dir_up_to_10", 10'(v), 1'b1, 1'b0);
            cyc(10);
            check_out();
        end
        cyc(7);
        sw_dir = 1'b0;
        expect_out("dir_down_at_10", 10'd9, 1'b1, 1'b0);
        cyc(3);
        check_out();
        expect_out("dir_down_next", 10'd8, 1'b1, 1'b0);
        cyc(10);
        check_out();
        cyc(7);
        sw_dir = 1'b1;
        expect_out("dir_up_again", 10'd9, 1'b1, 1'b0);
        cyc(3);
        check_out();
        for (int v = 10; v <= 20; v++) begin
            expect_out("dir_up_to_20", 10'(v), 1'b1, 1'b0);
            cyc(10);
            check_out();
        end
        cyc(7);
        sw_dir = 1'b0;
        expect_out("dir_down_at_20", 10'd19, 1'b1, 1'b0);
        cyc(3);
        check_out();
        expect_out("dir_down_after_20", 10'd18, 1'b1, 1'b0);
        cyc(10);
        check_out();

        // Clear and start/stop in the same cycle at 42
        clear_press();
        cyc(10);
        sw_dir = 1'b1;
        start_press();
        expect_out("at_42", 10'd42, 1'b1, 1'b0);
        cyc(420);
        check_out();
        key_clr_n = 1'b0;
        key_ss_n  = 1'b0;
        expect_out("clear_wins", 10'd0, 1'b0, 1'b0);
        cyc(7);
        key_clr_n = 1'b1;
        key_ss_n  = 1'b1;
        check_out();
        expect_out("no_toggle_after_clear", 10'd0, 1'b0, 1'b0);
        cyc(20);
        check_out();

        // Reset mid-count
        start_press();
        expect_out("rst_mid_count", 10'd0, 1'b0, 1'b0);
        cyc(25);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
